// File: rtl/gyr_pkg.sv
// Shared definitions for the gyrator trim controller and its helpers.
//   - gyr_state_e : calibration FSM state encoding
//   - GYR_*       : default bank geometry and timing
//   - gyr_idx_w   : index width for an n-entry selector (never below 1)
package gyr_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_TRIAL,
        S_SETTLE,
        S_DECIDE,
        S_DONE
    } gyr_state_e;

    localparam int GYR_NCH      = 4;
    localparam int GYR_TW       = 6;
    localparam int GYR_SETTLE   = 16;
    localparam int GYR_TRIM_RST = 1 << (GYR_TW - 1);

    function automatic int gyr_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gyr_cmp_sync.sv
// Two-flop synchroniser for an asynchronous comparator output.
//   clk_i : sampling clock
//   rst_i : asynchronous active-high reset, clears both flops
//   d_i   : asynchronous input
//   q_o   : synchronised output (two clock latency)
module gyr_cmp_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/gyrator_trim_sar.sv
// Successive-approximation gm trim controller for a bank of gyrator channels.
//   wb_clk_i / wb_rst_i   : clock, asynchronous active-high reset
//   start_i, abort_i      : sweep start pulse, sweep abort level
//   ch_mask_i             : channels to calibrate, captured at start
//   cmp_i                 : async comparator, 1 = gm too high
//   wr_en_i/wr_ch_i/wr_data_i : manual trim write (IDLE only)
//   trim_o                : packed trim codes, channel c at [c*TW +: TW]
//   cur_ch_o, cal_en_o    : comparator mux select and path enable
//   busy_o, done_o        : sweep active, end-of-sweep pulse
//
// state  | meaning
// IDLE   | waiting for start, manual writes accepted
// SCAN   | find next masked channel at or above idx
// TRIAL  | set the bit under test, load settle timer
// SETTLE | wait for analog path and comparator sync
// DECIDE | keep or drop the bit, step to next bit/channel
// DONE   | one-cycle done pulse
module gyrator_trim_sar
    import gyr_pkg::*;
#(
    parameter int NCH      = GYR_NCH,
    parameter int TW       = GYR_TW,
    parameter int SETTLE   = GYR_SETTLE,
    parameter int TRIM_RST = 1 << (TW - 1)
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [NCH-1:0]            ch_mask_i,
    input  logic                      cmp_i,
    input  logic                      wr_en_i,
    input  logic [gyr_idx_w(NCH)-1:0] wr_ch_i,
    input  logic [TW-1:0]             wr_data_i,
    output logic [NCH*TW-1:0]         trim_o,
    output logic [gyr_idx_w(NCH)-1:0] cur_ch_o,
    output logic                      cal_en_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int CW   = gyr_idx_w(NCH);
    localparam int BW   = gyr_idx_w(TW);
    localparam int CNTW = gyr_idx_w(SETTLE);

    gyr_state_e                state_q;
    logic [NCH-1:0][TW-1:0]    trim_q;
    logic [NCH-1:0]            mask_q;
    logic [CW:0]               idx_q;    // one extra bit so idx can reach NCH
    logic [CW-1:0]             cur_ch_q;
    logic [BW-1:0]             bit_q;
    logic [CNTW-1:0]           cnt_q;
    logic [TW-1:0]             bak_q;
    logic                      cal_en_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      cmp_s;

    logic                      scan_hit_d;
    logic [CW-1:0]             scan_ch_d;

    gyr_cmp_sync u_cmp_sync (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .d_i   (cmp_i),
        .q_o   (cmp_s)
    );

    // Lowest masked channel at or above idx; descending loop so the lowest wins.
    always_comb begin
        scan_hit_d = 1'b0;
        scan_ch_d  = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (mask_q[c] && (c >= int'(idx_q))) begin
                scan_hit_d = 1'b1;
                scan_ch_d  = CW'(c);
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            for (int c = 0; c < NCH; c++) trim_q[c] <= TW'(TRIM_RST);
            mask_q   <= '0;
            idx_q    <= '0;
            cur_ch_q <= '0;
            bit_q    <= '0;
            cnt_q    <= '0;
            bak_q    <= '0;
            cal_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE && abort_i) begin
                // Only a channel mid-search holds a partial code worth undoing.
                if (state_q inside {S_TRIAL, S_SETTLE, S_DECIDE})
                    trim_q[cur_ch_q] <= bak_q;
                state_q  <= S_IDLE;
                busy_q   <= 1'b0;
                cal_en_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (wr_en_i && (int'(wr_ch_i) < NCH))
                            trim_q[wr_ch_i] <= wr_data_i;
                        if (start_i && !abort_i) begin
                            mask_q  <= ch_mask_i;
                            idx_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= S_SCAN;
                        end
                    end
                    S_SCAN: begin
                        if (scan_hit_d) begin
                            cur_ch_q          <= scan_ch_d;
                            bak_q             <= trim_q[scan_ch_d];
                            trim_q[scan_ch_d] <= '0;
                            bit_q             <= BW'(TW - 1);
                            cal_en_q          <= 1'b1;
                            state_q           <= S_TRIAL;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                    S_TRIAL: begin
                        trim_q[cur_ch_q][bit_q] <= 1'b1;
                        cnt_q                   <= CNTW'(SETTLE - 1);
                        state_q                 <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (cnt_q == '0) state_q <= S_DECIDE;
                        else             cnt_q   <= cnt_q - 1'b1;
                    end
                    S_DECIDE: begin
                        if (cmp_s) trim_q[cur_ch_q][bit_q] <= 1'b0;
                        if (bit_q != '0) begin
                            bit_q   <= bit_q - 1'b1;
                            state_q <= S_TRIAL;
                        end else begin
                            // Past the last channel idx becomes NCH and SCAN finds nothing.
                            idx_q    <= {1'b0, cur_ch_q} + (CW + 1)'(1);
                            cal_en_q <= 1'b0;
                            state_q  <= S_SCAN;
                        end
                    end
                    S_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign trim_o   = trim_q;
    assign cur_ch_o = cur_ch_q;
    assign cal_en_o = cal_en_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_gyrator_trim_sar.sv
module tb_gyrator_trim_sar;

    localparam int NCH    = 4;
    localparam int TW     = 6;
    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, abort_i, cmp_i, wr_en_i;
    logic [3:0]  ch_mask_i;
    logic [1:0]  wr_ch_i;
    logic [5:0]  wr_data_i;
    logic [23:0] trim_o;
    logic [1:0]  cur_ch_o;
    logic        cal_en_o, busy_o, done_o;

    logic        wr5_en;
    logic [2:0]  wr5_ch;
    logic [5:0]  wr5_data;
    logic [29:0] trim5;
    logic [2:0]  cur5;
    logic        cal5, busy5, done5;

    int          tgt [NCH];
    int          exp_trim [NCH];
    int          exp5 [5];
    logic [1:0]  visits [$];
    int          passed = 0;
    int          total  = 0;
    int          failed = 0;

    always #5 clk = ~clk;

    // Comparator model: trips when the channel under test is above its target.
    assign cmp_i = (int'(trim_o[int'(cur_ch_o)*TW +: TW]) > tgt[cur_ch_o]);

    gyrator_trim_sar #(.NCH(NCH), .TW(TW), .SETTLE(SETTLE)) dut (
        .wb_clk_i (clk),       .wb_rst_i (rst),
        .start_i  (start_i),   .abort_i  (abort_i),
        .ch_mask_i(ch_mask_i), .cmp_i    (cmp_i),
        .wr_en_i  (wr_en_i),   .wr_ch_i  (wr_ch_i),
        .wr_data_i(wr_data_i), .trim_o   (trim_o),
        .cur_ch_o (cur_ch_o),  .cal_en_o (cal_en_o),
        .busy_o   (busy_o),    .done_o   (done_o)
    );

    // Five-channel instance: lets an out-of-range write channel be expressed.
    gyrator_trim_sar #(.NCH(5), .TW(TW), .SETTLE(SETTLE)) dut5 (
        .wb_clk_i (clk),       .wb_rst_i (rst),
        .start_i  (1'b0),      .abort_i  (1'b0),
        .ch_mask_i(5'b0),      .cmp_i    (1'b0),
        .wr_en_i  (wr5_en),    .wr_ch_i  (wr5_ch),
        .wr_data_i(wr5_data),  .trim_o   (trim5),
        .cur_ch_o (cur5),      .cal_en_o (cal5),
        .busy_o   (busy5),     .done_o   (done5)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [23:0] exp_vec();
        logic [23:0] v;
        for (int c = 0; c < NCH; c++) v[c*TW +: TW] = 6'(exp_trim[c]);
        return v;
    endfunction

    function automatic logic [29:0] exp_vec5();
        logic [29:0] v;
        for (int c = 0; c < 5; c++) v[c*TW +: TW] = 6'(exp5[c]);
        return v;
    endfunction

    task automatic run_sweep(input logic [3:0] m, output int bcyc, output int dcnt, output int to);
        bit seen;
        visits.delete();
        bcyc = 0; dcnt = 0; to = 1; seen = 0;
        @(negedge clk); start_i = 1'b1; ch_mask_i = m;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (k == 0) begin start_i = 1'b0; ch_mask_i = 4'($urandom); end
            if (k == 5 && m != 4'b0) begin start_i = 1'b1; ch_mask_i = ~m; end
            if (k == 6) start_i = 1'b0;
            if (busy_o) begin bcyc++; seen = 1; end
            if (done_o) dcnt++;
            if (cal_en_o && (visits.size() == 0 || visits[$] != cur_ch_o))
                visits.push_back(cur_ch_o);
            if (seen && !busy_o) begin to = 0; break; end
        end
    endtask

    task automatic sweep_check(input logic [3:0] m, input string tag);
        int bcyc, dcnt, to, n, vi;
        run_sweep(m, bcyc, dcnt, to);
        n = $countones(m);
        chk({tag, "_timeout"}, 64'(to), 64'd0);
        chk({tag, "_busy_cycles"}, 64'(bcyc), 64'((n + 1) + n * TW * (SETTLE + 2) + 1));
        chk({tag, "_done_pulses"}, 64'(dcnt), 64'd1);
        for (int c = 0; c < NCH; c++) if (m[c]) exp_trim[c] = tgt[c];
        chk({tag, "_trims"}, 64'(trim_o), 64'(exp_vec()));
        chk({tag, "_visit_count"}, 64'(visits.size()), 64'(n));
        vi = 0;
        for (int c = 0; c < NCH; c++) begin
            if (m[c] && vi < visits.size()) begin
                chk($sformatf("%s_visit%0d", tag, vi), 64'(visits[vi]), 64'(c));
                vi++;
            end
        end
    endtask

    task automatic wr4(input int ch, input int data);
        @(negedge clk); wr_en_i = 1'b1; wr_ch_i = 2'(ch); wr_data_i = 6'(data);
        @(negedge clk); wr_en_i = 1'b0;
    endtask

    task automatic wr5(input int ch, input int data);
        @(negedge clk); wr5_en = 1'b1; wr5_ch = 3'(ch); wr5_data = 6'(data);
        @(negedge clk); wr5_en = 1'b0;
        if (ch < 5) exp5[ch] = data;
    endtask

    initial begin
        int k, found, dcnt, pre1;
        logic [3:0] m;

        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; wr_en_i = 1'b0;
        ch_mask_i = '0; wr_ch_i = '0; wr_data_i = '0;
        wr5_en = 1'b0; wr5_ch = '0; wr5_data = '0;
        for (int c = 0; c < NCH; c++) begin tgt[c] = 0; exp_trim[c] = 32; end
        for (int c = 0; c < 5; c++) exp5[c] = 32;

        repeat (3) @(negedge clk);
        chk("rst_trims", 64'(trim_o), 64'(exp_vec()));
        chk("rst_cur_ch", 64'(cur_ch_o), 64'd0);
        chk("rst_cal_en", 64'(cal_en_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        tgt[0] = 42;
        sweep_check(4'b0001, "single");

        tgt[0] = 0; tgt[1] = 63; tgt[2] = 17; tgt[3] = 40;
        sweep_check(4'b1111, "full");

        for (int c = 0; c < NCH; c++) tgt[c] = 5;
        sweep_check(4'b1010, "sparse");
        sweep_check(4'b0000, "empty");

        wr4(2, 6'h15);
        exp_trim[2] = 6'h15;
        chk("wr_idle_ch2", 64'(trim_o[2*TW +: TW]), 64'h15);
        chk("wr_idle_all", 64'(trim_o), 64'(exp_vec()));

        // Abort during channel 1 settle; a write to channel 2 while busy must be dropped.
        tgt[0] = int'($urandom_range(0, 63));
        tgt[1] = int'($urandom_range(0, 63));
        pre1 = exp_trim[1];
        dcnt = 0; found = 0;
        @(negedge clk); start_i = 1'b1; ch_mask_i = 4'b0011;
        k = 0;
        while (k < 2000 && found == 0) begin
            @(negedge clk);
            if (k == 0) begin
                start_i = 1'b0; wr_en_i = 1'b1; wr_ch_i = 2'd2; wr_data_i = 6'h3F;
            end
            if (k == 1) wr_en_i = 1'b0;
            if (done_o) dcnt++;
            if (cal_en_o && cur_ch_o == 2'd1) found = 1;
            k++;
        end
        chk("abort_reach_ch1", 64'(found), 64'd1);
        @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        if (done_o) dcnt++;
        exp_trim[0] = tgt[0];
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_cal_en", 64'(cal_en_o), 64'd0);
        chk("abort_ch1_restored", 64'(trim_o[1*TW +: TW]), 64'(pre1));
        chk("abort_trims", 64'(trim_o), 64'(exp_vec()));
        repeat (3) begin
            @(negedge clk);
            if (done_o) dcnt++;
        end
        chk("abort_no_done", 64'(dcnt), 64'd0);

        tgt[1] = int'($urandom_range(0, 63));
        sweep_check(4'b0010, "restart");

        for (int r = 0; r < 4; r++) begin
            m = 4'($urandom_range(1, 15));
            for (int c = 0; c < NCH; c++) tgt[c] = int'($urandom_range(0, 63));
            sweep_check(m, $sformatf("rand%0d", r));
        end

        wr5(4, 6'h11);
        chk("wr5_ch4", 64'(trim5[4*TW +: TW]), 64'h11);
        wr5(5, 6'h2A);
        chk("wr5_ch5_ignored", 64'(trim5), 64'(exp_vec5()));
        wr5(7, 6'h07);
        chk("wr5_ch7_ignored", 64'(trim5), 64'(exp_vec5()));

        @(negedge clk); start_i = 1'b1; ch_mask_i = 4'b1111;
        for (int c = 0; c < NCH; c++) tgt[c] = int'($urandom_range(0, 63));
        @(negedge clk); start_i = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_active", 64'(busy_o), 64'd1);
        rst = 1'b1;
        #1;
        for (int c = 0; c < NCH; c++) exp_trim[c] = 32;
        chk("midrst_trims", 64'(trim_o), 64'(exp_vec()));
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_cal_en", 64'(cal_en_o), 64'd0);
        chk("midrst_cur_ch", 64'(cur_ch_o), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
